// File: rtl/aes_mix_columns_iter.sv
// Iterative AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per RUN cycle.
// Define AES_INV_MIX_COLUMNS_EN to compile in InvMixColumns, selected per block by IN_INV.
module aes_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    input  logic         IN_INV,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] MIXED_DATA,
    output logic         BUSY,
    output logic [1:0]   dbg_state
);

    // Handshake: a transfer happens on a rising edge where VALID & READY are both high;
    // a producer holds VALID and its data until that edge, and READY never depends on VALID.

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    state_t       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic [31:0]  col_in, col_out;
    logic         accept;

`ifdef AES_INV_MIX_COLUMNS_EN
    logic         inv_q, inv_d;
`else
    logic         unused_in_inv;
    assign unused_in_inv = IN_INV;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [31:0] res;
        res = '0;
        for (int r = 0; r < 4; r++) a[r] = col[31 - 8*r -: 8];
        for (int r = 0; r < 4; r++) begin
            res[31 - 8*r -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                               ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return res;
    endfunction

`ifdef AES_INV_MIX_COLUMNS_EN
    // 0E/0B/0D/09 are built from the x2, x4, x8 multiples of each byte.
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31 - 8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            res[31 - 8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                               ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                               ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                               ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
        end
        return res;
    endfunction
`endif

    assign IN_READY = ~RST & ((state_q == IDLE) | ((state_q == DONE) & OUT_READY));
    assign accept   = IN_VALID & IN_READY;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        col_in  = '0;
        col_out = '0;
`ifdef AES_INV_MIX_COLUMNS_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            RUN: begin
                // One shared transform unit per group slot; the counter picks the columns.
                for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                    col_in = work_q[127 - 32*(int'(cnt_q) + j) -: 32];
`ifdef AES_INV_MIX_COLUMNS_EN
                    col_out = inv_q ? mix_inv(col_in) : mix_fwd(col_in);
`else
                    col_out = mix_fwd(col_in);
`endif
                    work_d[127 - 32*(int'(cnt_q) + j) -: 32] = col_out;
                end
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                if (OUT_READY) state_d = IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            state_d = RUN;
            work_d  = IN_DATA;
            cnt_d   = '0;
`ifdef AES_INV_MIX_COLUMNS_EN
            inv_d   = IN_INV;
`endif
        end
    end

    assign out_valid_d = (state_d == DONE);
    assign busy_d      = (state_d != IDLE);

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AES_INV_MIX_COLUMNS_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef AES_INV_MIX_COLUMNS_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign OUT_VALID  = out_valid_q;
    assign BUSY       = busy_q;
    assign MIXED_DATA = work_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Bench for aes_mix_columns_iter: three instances (1, 2, 4 columns per cycle) against a GF(2^8) reference model.
module tb_aes_mix_columns_iter;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid   [3];
    logic         in_ready   [3];
    logic [127:0] in_data    [3];
    logic         in_inv     [3];
    logic         out_valid  [3];
    logic         out_ready  [3];
    logic [127:0] mixed_data [3];
    logic         busy       [3];
    logic [1:0]   unused_dbg_state [3];

    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] exp_q [$];

    // clock / reset
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk        (clk),
            .RST        (rst),
            .IN_VALID   (in_valid[g]),
            .IN_READY   (in_ready[g]),
            .IN_DATA    (in_data[g]),
            .IN_INV     (in_inv[g]),
            .OUT_VALID  (out_valid[g]),
            .OUT_READY  (out_ready[g]),
            .MIXED_DATA (mixed_data[g]),
            .BUSY       (busy[g]),
            .dbg_state  (unused_dbg_state[g])
        );
    end

    // reference model: carry-less multiply then reduce by 0x11B
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic eff_inv(input logic inv);
`ifdef AES_INV_MIX_COLUMNS_EN
        return inv;
`else
        return 1'b0 & inv;
`endif
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   o;
        logic [127:0] r;
        r = '0;
        if (inv) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                o = '0;
                for (int k = 0; k < 4; k++) o = o ^ gf_mul(coef[k], a[(row + k) % 4]);
                r[127 - 32*c - 8*row -: 8] = o;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver: one block through instance idx, latency and data checked against the scoreboard
    task automatic do_block(input string tag, input int idx, input logic [127:0] data,
                            input logic inv, output logic [127:0] got);
        int waited;
        int lat;
        exp_q.push_back(ref_mix(data, eff_inv(inv)));
        @(negedge clk);
        waited = 0;
        while (!in_ready[idx] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        in_valid[idx] = 1'b1;
        in_data[idx]  = data;
        in_inv[idx]   = inv;
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        in_data[idx]  = rand128();
        in_inv[idx]   = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid[idx] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 128'(lat), 128'(4 >> idx));
        got = mixed_data[idx];
        check_eq(tag, got, exp_q.pop_front());
        @(negedge clk);
        out_ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got, back, s, held, d2, d3;
        int           lat, cyc, n_hi;
        int           rises [$];

        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_inv[i]    = 1'b0;
            out_ready[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 128'(in_ready[0]), 128'(0));
        check_eq("rst_out_valid", 128'(out_valid[0]), 128'(0));
        check_eq("rst_busy", 128'(busy[0]), 128'(0));
        check_eq("rst_mixed", mixed_data[0], 128'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_eq("post_rst_in_ready", 128'(in_ready[i]), 128'(1));

        // FIPS-197 columns on every column width
        for (int i = 0; i < 3; i++) begin
            do_block("fips_fwd", i, FIPS_IN, 1'b0, got);
            check_eq("fips_fwd_const", got, FIPS_OUT);
        end

`ifdef AES_INV_MIX_COLUMNS_EN
        for (int i = 0; i < 3; i++) begin
            do_block("fips_inv", i, FIPS_OUT, 1'b1, got);
            check_eq("fips_inv_const", got, FIPS_IN);
        end
`else
        do_block("inv_ignored", 0, FIPS_IN, 1'b1, got);
        check_eq("inv_ignored_const", got, FIPS_OUT);
`endif

        // random states, with round trip when the inverse is present
        for (int i = 0; i < 9; i++) begin
            s = rand128();
            do_block("rand_fwd", i % 3, s, 1'b0, got);
`ifdef AES_INV_MIX_COLUMNS_EN
            do_block("rand_inv", (i + 1) % 3, got, 1'b1, back);
            check_eq("round_trip", back, s);
`else
            do_block("rand_inv_flag", (i + 1) % 3, s, 1'b1, back);
`endif
        end

        // backpressure in DONE, then handover in the same cycle
        s  = rand128();
        d2 = rand128();
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = s;
        in_inv[0]   = 1'b0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        held = mixed_data[0];
        check_eq("bp_first", held, ref_mix(s, 1'b0));
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = d2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_in_ready", 128'(in_ready[0]), 128'(0));
            check_eq("bp_out_valid", 128'(out_valid[0]), 128'(1));
            check_eq("bp_stable", mixed_data[0], held);
        end
        out_ready[0] = 1'b1;
        #1;
        check_eq("handover_in_ready", 128'(in_ready[0]), 128'(1));
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        check_eq("handover_busy", 128'(busy[0]), 128'(1));
        check_eq("handover_out_valid", 128'(out_valid[0]), 128'(0));
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("handover_latency", 128'(lat), 128'(4));
        check_eq("handover_data", mixed_data[0], ref_mix(d2, 1'b0));
        @(negedge clk);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;

        // throughput with OUT_READY held high
        d3 = rand128();
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = d3;
        cyc = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid[0]) begin
                rises.push_back(cyc);
                check_eq("tput_data", mixed_data[0], ref_mix(d3, 1'b0));
            end
        end
        check_eq("tput_count", 128'(rises.size()), 128'(3));
        for (int k = 1; k < rises.size(); k++) begin
            check_eq("tput_period", 128'(rises[k] - rises[k-1]), 128'(5));
        end
        in_valid[0] = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;

        // reset in the middle of RUN
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = rand128();
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
        check_eq("mid_rst_mixed", mixed_data[0], 128'h0);
        check_eq("mid_rst_in_ready", 128'(in_ready[0]), 128'(0));
        check_eq("mid_rst_busy", 128'(busy[0]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("after_rst_in_ready", 128'(in_ready[0]), 128'(1));
        n_hi = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (out_valid[0]) n_hi++;
        end
        check_eq("abandoned_no_valid", 128'(n_hi), 128'(0));
        do_block("all_01", 0, {16{8'h01}}, 1'b0, got);
        check_eq("all_01_const", got, {16{8'h01}});
        do_block("all_c6", 0, {16{8'hc6}}, 1'b0, got);
        check_eq("all_c6_const", got, {16{8'hc6}});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
